// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM data-memory controller.
// Holds the FSM state encoding, default timing/base-address parameters
// and the bus widths used by the controller, its interface and sub-module.
package sram_pkg;

    localparam int unsigned SRAM_WAIT_DEFAULT = 3;
    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

    localparam int unsigned WAIT_CNT_W  = 4;
    localparam int unsigned CPU_DATA_W  = 32;
    localparam int unsigned SRAM_DATA_W = 16;
    localparam int unsigned SRAM_ADDR_W = 18;
    // Half-word pair index: SRAM address without its phase bit.
    localparam int unsigned HW_PAIR_W   = SRAM_ADDR_W - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } sram_state_e;

endpackage

// File: rtl/sram_controller_if.sv
// CPU-side MEM-stage bus of the SRAM controller.
//   master : pipeline side (drives requests, address, store data)
//   slave  : controller side (returns load data, ready, pipeline freeze)
interface sram_controller_if;
    import sram_pkg::*;

    logic                  MEM_R_EN;
    logic                  MEM_W_EN;
    logic [CPU_DATA_W-1:0] ALU_Res;
    logic [CPU_DATA_W-1:0] ST_val;
    logic [CPU_DATA_W-1:0] read_data;
    logic                  ready;
    logic                  SRAM_freeze;

    modport master (
        output MEM_R_EN, MEM_W_EN, ALU_Res, ST_val,
        input  read_data, ready, SRAM_freeze
    );

    modport slave (
        input  MEM_R_EN, MEM_W_EN, ALU_Res, ST_val,
        output read_data, ready, SRAM_freeze
    );

endinterface

// File: rtl/sram_wait_counter.sv
// Phase timer for the SRAM controller.
// Ports: clk, rst (async, active-high), clr (synchronous clear, wins over en),
//        en (count up), tc_c (combinational terminal count: count == SRAM_WAIT-1).
module sram_wait_counter
    import sram_pkg::*;
#(
    parameter int unsigned SRAM_WAIT = SRAM_WAIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc_c
);

    logic [WAIT_CNT_W-1:0] count;

    // Cycle counter within the current phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WAIT_CNT_W'(1);
        end
    end

    assign tc_c = (count == WAIT_CNT_W'(SRAM_WAIT - 1));

endmodule

// File: rtl/sram_controller.sv
// 32-bit data-memory controller over a 16-bit asynchronous SRAM.
// Each access is split into a LOW and a HIGH half-word phase of SRAM_WAIT
// cycles each, followed by a one-cycle DONE where ready is asserted.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   bus (slave)    : MEM_R_EN/MEM_W_EN/ALU_Res/ST_val in; read_data, ready,
//                    SRAM_freeze (combinational pipeline hold) out
//   SRAM_DQ        : bidirectional 16-bit SRAM data bus
//   SRAM_ADDR      : half-word address
//   SRAM_*_N       : active-low SRAM strobes (CE/OE/UB/LB tied active)
module sram_controller
    import sram_pkg::*;
#(
    parameter int unsigned SRAM_WAIT = SRAM_WAIT_DEFAULT,
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_controller_if.slave       bus,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N
);

    sram_state_e           state_q;
    sram_state_e           state_d;
    logic                  is_write_q;
    logic [CPU_DATA_W-1:0] read_data_q;
    logic                  req;
    logic                  latch_type;
    logic                  cnt_clr;
    logic                  cnt_en;
    logic                  tc;
    logic                  in_phase;
    logic                  dq_oe;
    logic [SRAM_DATA_W-1:0] dq_out;
    logic [HW_PAIR_W-1:0]  hw_pair;

    assign req      = bus.MEM_R_EN | bus.MEM_W_EN;
    assign in_phase = (state_q == LOW) || (state_q == HIGH);

    sram_wait_counter #(
        .SRAM_WAIT (SRAM_WAIT)
    ) u_wait_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .tc_c (tc)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and phase-timer control; counter restarts at each phase edge.
    always_comb begin
        state_d    = state_q;
        cnt_clr    = 1'b1;
        cnt_en     = 1'b0;
        latch_type = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d    = LOW;
                    latch_type = 1'b1;
                end
            end
            LOW: begin
                cnt_en  = 1'b1;
                cnt_clr = tc;
                if (tc) begin
                    state_d = HIGH;
                end
            end
            HIGH: begin
                cnt_en  = 1'b1;
                cnt_clr = tc;
                if (tc) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Access type is frozen for the whole access; both enables mean write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_write_q <= 1'b0;
        end else if (latch_type) begin
            is_write_q <= bus.MEM_W_EN;
        end
    end

    // Load data: each half captured on the last cycle of its phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data_q <= '0;
        end else if (!is_write_q && tc) begin
            if (state_q == LOW) begin
                read_data_q[SRAM_DATA_W-1:0] <= SRAM_DQ;
            end else if (state_q == HIGH) begin
                read_data_q[CPU_DATA_W-1:SRAM_DATA_W] <= SRAM_DQ;
            end
        end
    end

    // Word index after rebasing; modulo-2^32 subtract, byte offset dropped.
    assign hw_pair = HW_PAIR_W'((bus.ALU_Res - BASE_ADDR) >> 2);

    assign SRAM_ADDR = {hw_pair, (state_q == HIGH)};

    assign dq_oe  = is_write_q && in_phase;
    assign dq_out = (state_q == HIGH) ? bus.ST_val[CPU_DATA_W-1:SRAM_DATA_W]
                                      : bus.ST_val[SRAM_DATA_W-1:0];

    assign SRAM_DQ   = dq_oe ? dq_out : {SRAM_DATA_W{1'bz}};
    assign SRAM_WE_N = !dq_oe;
    assign SRAM_OE_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    // Hold the pipeline from the request cycle until DONE; never under reset.
    assign bus.SRAM_freeze = !rst && (((state_q == IDLE) && req) || in_phase);
    assign bus.ready       = (state_q == DONE);
    assign bus.read_data   = read_data_q;

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter SRAM_WAIT, default 3, wait cycles held per 16-bit SRAM phase (legal range 1..15).
REQ-002 Parameter BASE_ADDR, default 32'd1024, data-memory base subtracted from the CPU address.
REQ-003 clk  input  1  clock, rising-edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 MEM_R_EN  input  1  MEM-stage load request.
REQ-006 MEM_W_EN  input  1  MEM-stage store request.
REQ-007 ALU_Res  input  32  byte address from EXE/MEM register.
REQ-008 ST_val  input  32  store data.
REQ-009 read_data  output  32  registered load result.
REQ-010 ready  output  1  access complete this cycle.
REQ-011 SRAM_freeze  output  1  pipeline hold; drives freeze input of every pipeline register.
REQ-012 SRAM_DQ  inout  16  external data bus.
REQ-013 SRAM_ADDR  output  18  external half-word address.
REQ-014 SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  output  1 each  active-low SRAM controls.

Function
REQ-015 The FSM SHALL have states IDLE, LOW, HIGH, DONE.
REQ-016 In IDLE, when MEM_R_EN or MEM_W_EN is high, next state SHALL be LOW; otherwise IDLE.
REQ-017 LOW SHALL last exactly SRAM_WAIT cycles, then HIGH. HIGH SHALL last exactly SRAM_WAIT cycles, then DONE. DONE SHALL last one cycle, then IDLE.
REQ-018 SRAM_freeze SHALL be combinational and high in IDLE with a request pending, and in LOW and HIGH. It SHALL be low in DONE and in IDLE without a request.
REQ-019 Freeze duration per access SHALL be 1+2*SRAM_WAIT cycles (7 at default).
REQ-020 ready SHALL be high only in DONE.
REQ-021 Address mapping: a = ALU_Res - BASE_ADDR.
  - LOW phase: SRAM_ADDR = {a[18:2],1'b0}.
  - HIGH phase: SRAM_ADDR = {a[18:2],1'b1}.
  - a[1:0] ignored. Subtraction wraps modulo 2^32.
REQ-022 Write, LOW phase: drive SRAM_DQ = ST_val[15:0] and SRAM_WE_N = 0 for all cycles of the phase.
REQ-023 Write, HIGH phase: drive SRAM_DQ = ST_val[31:16] and SRAM_WE_N = 0 for all cycles of the phase.
REQ-024 Read: SRAM_DQ SHALL be high-Z and SRAM_WE_N = 1.
  - Last LOW cycle: capture SRAM_DQ into read_data[15:0].
  - Last HIGH cycle: capture SRAM_DQ into read_data[31:16].
REQ-025 read_data SHALL hold its value until the next read overwrites it; writes SHALL NOT modify it.
REQ-026 SRAM_CE_N, SRAM_OE_N, SRAM_UB_N and SRAM_LB_N SHALL be tied low.
REQ-027 SRAM_DQ SHALL be high-Z in every state except write LOW/HIGH.
REQ-028 Access type SHALL be latched on the IDLE->LOW transition and held through DONE.
REQ-029 Simultaneous MEM_R_EN and MEM_W_EN SHALL be treated as a write.
REQ-030 A request present in the cycle after DONE SHALL start a new access.
  - No back-to-back bubble is inserted beyond the IDLE cycle.
REQ-031 Input changes while in LOW, HIGH or DONE SHALL be ignored.
  - Exception: ALU_Res and ST_val are sampled live; the pipeline holds them stable under freeze.

Reset
REQ-032 On rst the controller SHALL immediately enter IDLE, including mid-access.
  - read_data = 0, wait counter = 0, latched type = read.
  - SRAM_WE_N = 1, SRAM_DQ high-Z, SRAM_freeze = 0, ready = 0.
REQ-033 A write interrupted by rst SHALL leave SRAM contents undefined; no completion is signalled.

Structure
REQ-034 Package sram_pkg SHALL hold the state enumeration, BASE_ADDR default and SRAM_WAIT default.
REQ-035 Phase timing SHALL be a sub-module sram_wait_counter: 4-bit counter with clear and terminal-count output (count == SRAM_WAIT-1).
REQ-036 All other logic SHALL reside in sram_controller; the SRAM model belongs only to the bench.

Verification
REQ-037 Write 32'hDEADBEEF at ALU_Res 1024+8:
  - SRAM half-words 4 and 5 SHALL be 16'hBEEF and 16'hDEAD.
  - SRAM_freeze SHALL be high for exactly 7 cycles, then ready SHALL pulse for 1 cycle.
REQ-038 Read back at ALU_Res 1032: read_data SHALL be 32'hDEADBEEF in DONE, and SHALL be held afterward.
REQ-039 Back-to-back write then read at 1036:
  - Second access SHALL start the cycle after DONE.
  - Total freeze SHALL be 14 of 16 cycles.
REQ-040 Assert rst during the HIGH phase of a read:
  - Same cycle: freeze = 0, DQ high-Z, WE_N = 1.
  - read_data = 0; next request SHALL complete normally.
REQ-041 MEM_R_EN = MEM_W_EN = 1 with ST_val 32'h12345678 at 1024:
  - SRAM SHALL be written.
  - read_data SHALL remain unchanged.
REQ-042 No requests for 20 cycles:
  - freeze = 0, ready = 0, WE_N = 1, DQ high-Z throughout.
